// File: rtl/reg_cmd_pkg.sv
// Shared types and constants for the UART command controller.
// State encoding, frame opcodes and a helper naming the states that
// belong to an open frame (the ones a stalled sender can leave hanging).
package reg_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_WAIT = 3'd4,
        S_TX_SEND = 3'd5
    } state_e;

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;

    // States in which the frame timer runs; TX_SEND waits on the TX side
    // only, so it is never timed out.
    function automatic logic is_timed(input state_e s);
        return (s == S_WR_ADDR) || (s == S_WR_DATA) ||
               (s == S_RD_ADDR) || (s == S_RD_WAIT);
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Idle-cycle counter for an open command frame.
// Counts while run is high, restarts on clr, and raises expire while the
// count sits at TIMEOUT_CYC-1 so the FSM can abort on that edge.
// Only instantiated when CMD_TIMEOUT_EN is defined.
module frame_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = run && (cnt_q == LAST);

    // Next count: restart on a new byte or state entry, hold at zero when idle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !run) begin
            cnt_d = '0;
        end else if (!expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_cmd_ctrl.sv
// Command controller: parses UART RX byte frames into register-file
// write/read strobes and returns read data to the UART TX path.
//   write frame: AA, addr, data      read frame: BB, addr
// Malformed opcodes/addresses and bytes arriving while a read is in
// flight pulse CMD_ERR. Define CMD_TIMEOUT_EN to abort frames that stall
// for TIMEOUT_CYC cycles. All outputs come straight from flops.
module reg_cmd_ctrl
    import reg_cmd_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ADDR        = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_P_DATA,
    input  logic             RX_D_VLD,
    output logic             WrEn,
    output logic             RdEn,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    input  logic [WIDTH-1:0] RdData,
    input  logic             RdData_Valid,
    output logic [WIDTH-1:0] TX_P_DATA,
    output logic             TX_D_VLD,
    input  logic             TX_Busy,
    output logic             CMD_ERR
);

    // Reject impossible configurations at elaboration.
    if (ADDR < 1 || ADDR > WIDTH || TIMEOUT_CYC < 2) begin : g_param_chk
        $error("reg_cmd_ctrl: need 1 <= ADDR <= WIDTH and TIMEOUT_CYC >= 2");
    end

    localparam logic [WIDTH-1:0] OP_WR = WIDTH'(CMD_WR);
    localparam logic [WIDTH-1:0] OP_RD = WIDTH'(CMD_RD);

    state_e           state_q, state_d;
    logic             wr_en_q, wr_en_d;
    logic             rd_en_q, rd_en_d;
    logic             tx_d_vld_q, tx_d_vld_d;
    logic             cmd_err_q, cmd_err_d;
    logic [ADDR-1:0]  address_q, address_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [WIDTH-1:0] tx_p_data_q, tx_p_data_d;

    logic             addr_ok;
    logic             tmr_expire;

    // Address bytes must fit the register file: every bit above ADDR zero.
    assign addr_ok = ((RX_P_DATA >> ADDR) == '0);

`ifdef CMD_TIMEOUT_EN
    logic tmr_run, tmr_clr, byte_acc;

    // A byte is consumed (not dropped) in IDLE and the address/data states.
    assign byte_acc = RX_D_VLD && (state_q == S_IDLE || state_q == S_WR_ADDR ||
                                   state_q == S_WR_DATA || state_q == S_RD_ADDR);
    assign tmr_run  = is_timed(state_q);
    assign tmr_clr  = byte_acc || (state_d != state_q);

    frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_timer (
        .clk    (CLK),
        .rst    (RST),
        .run    (tmr_run),
        .clr    (tmr_clr),
        .expire (tmr_expire)
    );
`else
    assign tmr_expire = 1'b0;
`endif

    // Frame parser: next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        tx_d_vld_d  = 1'b0;
        cmd_err_d   = 1'b0;
        address_d   = address_q;
        wr_data_d   = wr_data_q;
        tx_p_data_d = tx_p_data_q;

        case (state_q)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == OP_WR) begin
                        state_d = S_WR_ADDR;
                    end else if (RX_P_DATA == OP_RD) begin
                        state_d = S_RD_ADDR;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end

            S_WR_ADDR, S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (!addr_ok) begin
                        cmd_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        address_d = RX_P_DATA[ADDR-1:0];
                        if (state_q == S_WR_ADDR) begin
                            state_d = S_WR_DATA;
                        end else begin
                            rd_en_d = 1'b1;
                            state_d = S_RD_WAIT;
                        end
                    end
                end else if (tmr_expire) begin
                    cmd_err_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = S_IDLE;
                end else if (tmr_expire) begin
                    cmd_err_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            S_RD_WAIT: begin
                // Overrun: byte is dropped, the read carries on.
                if (RX_D_VLD) begin
                    cmd_err_d = 1'b1;
                end
                if (RdData_Valid) begin
                    tx_p_data_d = RdData;
                    // TX already free: hand the byte over without a TX_SEND stop.
                    if (!TX_Busy) begin
                        tx_d_vld_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d    = S_TX_SEND;
                    end
                end else if (tmr_expire) begin
                    cmd_err_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            S_TX_SEND: begin
                if (RX_D_VLD) begin
                    cmd_err_d = 1'b1;
                end
                if (!TX_Busy) begin
                    tx_d_vld_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            tx_d_vld_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            address_q   <= '0;
            wr_data_q   <= '0;
            tx_p_data_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            tx_d_vld_q  <= tx_d_vld_d;
            cmd_err_q   <= cmd_err_d;
            address_q   <= address_d;
            wr_data_q   <= wr_data_d;
            tx_p_data_q <= tx_p_data_d;
        end
    end

    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign TX_D_VLD  = tx_d_vld_q;
    assign CMD_ERR   = cmd_err_q;
    assign Address   = address_q;
    assign WrData    = wr_data_q;
    assign TX_P_DATA = tx_p_data_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Bench for reg_cmd_ctrl: frame-level stimulus pushes the expected
// strobes (with the cycle they must appear in) into per-kind queues; a
// monitor on the falling edge pops and compares whatever the DUT emits,
// and also plays the register file answering RdEn one cycle later.
module tb_reg_cmd_ctrl;

    localparam int W    = 8;
    localparam int A    = 4;
    localparam int TCYC = 1024;

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] RX_P_DATA = '0;
    logic         RX_D_VLD = 1'b0;
    logic         WrEn, RdEn, TX_D_VLD, CMD_ERR;
    logic [A-1:0] Address;
    logic [W-1:0] WrData, TX_P_DATA;
    logic [W-1:0] RdData = '0;
    logic         RdData_Valid = 1'b0;
    logic         TX_Busy = 1'b0;

    reg_cmd_ctrl #(.WIDTH(W), .ADDR(A), .TIMEOUT_CYC(TCYC)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .TX_Busy      (TX_Busy),
        .CMD_ERR      (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    ev_t wr_q[$];
    ev_t rd_q[$];
    ev_t tx_q[$];
    int  err_q[$];

    logic [7:0] ref_mem[16];   // what a correct register file holds
    logic [7:0] rf_mem[16];    // register file as written by the DUT
    logic       pend = 1'b0;
    logic [7:0] pend_d = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic ev_t mk_ev(input int c, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.cyc = c;
        e.a   = a;
        e.d   = d;
        return e;
    endfunction

    // Monitor and register-file responder.
    always @(negedge CLK) begin
        ev_t e;
        RdData_Valid = pend;
        RdData       = pend_d;
        pend         = RdEn;
        pend_d       = rf_mem[Address];
        if (WrEn || RdEn) chk("wr_rd_exclusive", {31'd0, WrEn && RdEn}, 32'd0);
        if (WrEn) begin
            chk("wr_expected", {31'd0, wr_q.size() > 0}, 32'd1);
            if (wr_q.size() > 0) begin
                e = wr_q.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", {28'd0, Address}, {24'd0, e.a});
                chk("wr_data", {24'd0, WrData}, {24'd0, e.d});
            end
            rf_mem[Address] = WrData;
        end
        if (RdEn) begin
            chk("rd_expected", {31'd0, rd_q.size() > 0}, 32'd1);
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                chk("rd_cycle", cyc, e.cyc);
                chk("rd_addr", {28'd0, Address}, {24'd0, e.a});
            end
        end
        if (TX_D_VLD) begin
            chk("tx_expected", {31'd0, tx_q.size() > 0}, 32'd1);
            if (tx_q.size() > 0) begin
                e = tx_q.pop_front();
                chk("tx_cycle", cyc, e.cyc);
                chk("tx_data", {24'd0, TX_P_DATA}, {24'd0, e.d});
            end
        end
        if (CMD_ERR) begin
            chk("err_expected", {31'd0, err_q.size() > 0}, 32'd1);
            if (err_q.size() > 0) chk("err_cycle", cyc, err_q.pop_front());
        end
    end

    // Present one byte for one cycle; k is the cycle it is sampled in.
    task automatic drive(input logic [7:0] b, output int k);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        k         = cyc;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int g);
        int k;
        drive(8'hAA, k);
        gap(g);
        drive({4'h0, a}, k);
        gap(g);
        drive(d, k);
        wr_q.push_back(mk_ev(k + 1, {4'h0, a}, d));
        ref_mem[a] = d;
    endtask

    // Read with TX_Busy high for b cycles starting at the address byte,
    // optionally with one overrun byte while the read is in flight.
    task automatic do_read(input logic [3:0] a, input int b, input bit ovr, input int g);
        int k, off, inj;
        drive(8'hBB, k);
        gap(g);
        off     = (b + 1 > 3) ? b + 1 : 3;
        TX_Busy = (b > 0);
        drive({4'h0, a}, k);
        rd_q.push_back(mk_ev(k + 1, {4'h0, a}, 8'h00));
        tx_q.push_back(mk_ev(k + off, 8'h00, ref_mem[a]));
        inj = ovr ? $urandom_range(1, off - 1) : 0;
        for (int i = 1; i <= off; i++) begin
            TX_Busy = (i < b);
            if (i == inj) begin
                RX_P_DATA = 8'($urandom);
                RX_D_VLD  = 1'b1;
                err_q.push_back(k + i + 1);
            end
            @(negedge CLK);
            RX_D_VLD = 1'b0;
        end
        TX_Busy = 1'b0;
    endtask

    task automatic bad_op(input logic [7:0] v);
        int k;
        drive(v, k);
        err_q.push_back(k + 1);
    endtask

    task automatic bad_addr(input logic [7:0] op, input logic [3:0] hi, input logic [3:0] lo, input int g);
        int k;
        drive(op, k);
        gap(g);
        drive({hi, lo}, k);
        err_q.push_back(k + 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wren"}, {31'd0, WrEn}, 32'd0);
        chk({tag, "_rden"}, {31'd0, RdEn}, 32'd0);
        chk({tag, "_addr"}, {28'd0, Address}, 32'd0);
        chk({tag, "_wrdata"}, {24'd0, WrData}, 32'd0);
        chk({tag, "_txdata"}, {24'd0, TX_P_DATA}, 32'd0);
        chk({tag, "_txvld"}, {31'd0, TX_D_VLD}, 32'd0);
        chk({tag, "_err"}, {31'd0, CMD_ERR}, 32'd0);
    endtask

    initial begin
        int k;
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'(8'h73 + 7 * i);   // entry 2 holds 0x81
            rf_mem[i]  = ref_mem[i];
        end

        gap(3);
        chk_outputs_zero("reset");
        RST = 1'b0;
        gap(2);

        // Directed frames.
        do_write(4'h5, 8'h3C, 0);
        do_read(4'h2, 0, 1'b0, 0);
        gap(2);
        do_read(4'h2, 10, 1'b0, 1);
        gap(1);
        bad_op(8'h55);
        bad_addr(8'hBB, 4'h1, 4'h5, 0);
        do_write(4'h1, 8'h7F, 0);
        do_read(4'h1, 0, 1'b1, 0);
        gap(2);

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0, 1: do_write(4'($urandom), 8'($urandom), $urandom_range(0, 2));
                2, 3: do_read(4'($urandom),
                              ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 12),
                              $urandom_range(0, 3) == 0, $urandom_range(0, 2));
                4: begin
                    do v = 8'($urandom); while (v == 8'hAA || v == 8'hBB);
                    bad_op(v);
                end
                default: bad_addr($urandom_range(0, 1) ? 8'hAA : 8'hBB,
                                  4'($urandom_range(1, 15)), 4'($urandom),
                                  $urandom_range(0, 2));
            endcase
            gap($urandom_range(0, 3));
        end

        // Stalled write frame.
        drive(8'hAA, k);
        drive(8'h03, k);
`ifdef CMD_TIMEOUT_EN
        err_q.push_back(k + TCYC + 1);
`endif
        gap(TCYC + 2);
        drive(8'h44, k);
`ifdef CMD_TIMEOUT_EN
        err_q.push_back(k + 1);
`else
        wr_q.push_back(mk_ev(k + 1, 8'h03, 8'h44));
        ref_mem[3] = 8'h44;
`endif
        gap(2);

        // Reset in the middle of a write frame.
        drive(8'hAA, k);
        drive(8'h07, k);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk_outputs_zero("midreset");
        bad_op(8'h44);
        do_write(4'hA, 8'h5A, 0);
        gap(10);

        chk("wr_left", wr_q.size(), 32'd0);
        chk("rd_left", rd_q.size(), 32'd0);
        chk("tx_left", tx_q.size(), 32'd0);
        chk("err_left", err_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_cmd_ctrl.md
# reg_cmd_ctrl

Command controller between the UART receive path and the register file. Parses byte frames from the UART RX deserializer into register-file write and read strobes. Returns read data to the UART TX path with a busy/valid handshake. Flags malformed frames, overruns and, when enabled, stalled frames.

## Interface
- WIDTH, 8: data and byte width.
- ADDR, 4: register address width; must be ≤ WIDTH.
- TIMEOUT_CYC, 1024: idle cycles allowed inside an open frame, used only with CMD_TIMEOUT_EN.

Ports:
- CLK  in  1  single clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- RX_P_DATA  in  WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle pulse per received byte.
- WrEn  out  1  register-file write strobe, one cycle.
- RdEn  out  1  register-file read strobe, one cycle.
- Address  out  ADDR  register-file address.
- WrData  out  WIDTH  register-file write data.
- RdData  in  WIDTH  register-file read data.
- RdData_Valid  in  1  register-file read-data qualifier, one cycle.
- TX_P_DATA  out  WIDTH  byte handed to TX.
- TX_D_VLD  out  1  one-cycle transfer pulse to TX.
- TX_Busy  in  1  TX cannot accept; TX_D_VLD is suppressed while high.
- CMD_ERR  out  1  one-cycle error pulse.

## Operation
- Frames:
  - Write: 0xAA, address byte, data byte.
  - Read: 0xBB, address byte.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE on a byte:
  - 0xAA → WR_ADDR.
  - 0xBB → RD_ADDR.
  - Any other value → CMD_ERR, stay in IDLE.
- Address byte:
  - Bits [WIDTH-1:ADDR] must be zero, otherwise CMD_ERR and return to IDLE.
  - Bits [ADDR-1:0] are latched into Address.
  - WR_ADDR → WR_DATA; RD_ADDR → RD_WAIT, issuing RdEn.
- WR_DATA on a byte: latch WrData, pulse WrEn, → IDLE.
- RD_WAIT on RdData_Valid: capture RdData into TX_P_DATA, → TX_SEND.
- TX_SEND: pulse TX_D_VLD in the first cycle TX_Busy is low, → IDLE.
- A byte arriving in RD_WAIT or TX_SEND is dropped and pulses CMD_ERR (overrun). The state does not change.
- WrEn and RdEn are never high together.
- Address, WrData and TX_P_DATA hold their last values between strobes.

## Timing
- Reset values: all outputs 0 and state IDLE on the first edge with RST=1. Reset mid-frame discards the partial frame.
- Every output is registered.
- Write: data byte with RX_D_VLD in cycle k → WrEn=1 in cycle k+1 with Address/WrData valid.
- Read:
  - Address byte in cycle k → RdEn=1 in cycle k+1.
  - RdData_Valid is expected in cycle k+2.
  - TX_D_VLD is in cycle k+3 at the earliest, when TX_Busy=0 in k+2.
- TX handshake: TX_D_VLD is asserted in cycle j+1, where j is the first TX_SEND cycle sampled with TX_Busy=0. TX_Busy is sampled, not combinationally forwarded.
- Back-to-back: a new opcode byte is accepted in the cycle WrEn is high (already back in IDLE).
- CMD_ERR is asserted the cycle after the offending byte.

## Configuration
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A counter clears on every accepted byte and on entry to WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT.
  - It increments each cycle in those states.
  - When it reaches TIMEOUT_CYC-1, the block pulses CMD_ERR next cycle and returns to IDLE.
  - TX_SEND is exempt.
- Undefined: no counter. Open frames wait indefinitely.

## Structure
- Package reg_cmd_pkg holds:
  - The state enum.
  - Constants CMD_WR=8'hAA and CMD_RD=8'hBB.
- Sub-module frame_timer (counter plus expiry pulse) is instantiated only under CMD_TIMEOUT_EN.
- The remainder is a single FSM module.

## Test plan
- Write frame: bytes AA, 05, 3C → single WrEn one cycle after 3C, Address=5, WrData=0x3C; RdEn stays 0.
- Read frame: bytes BB, 02; model returns 0x81 one cycle after RdEn → TX_D_VLD pulse with TX_P_DATA=0x81 at k+3.
- Backpressure: same read with TX_Busy high for 10 cycles → TX_D_VLD exactly once, the cycle after TX_Busy falls.
- Errors:
  - Opcode 0x55 → CMD_ERR only.
  - Frame BB, 15 → CMD_ERR, no RdEn.
  - A following AA, 01, 7F frame → normal write.
- Overrun: byte sent during RD_WAIT → CMD_ERR; the read still completes with the correct data.
- Timeout/reset:
  - AA, 03 then silence for TIMEOUT_CYC cycles → CMD_ERR and IDLE with the macro defined; still in WR_DATA with it undefined.
  - RST mid-frame → IDLE with outputs 0.
